load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_lane_align.sv | 34 +++
 rtl/load_store_unit.sv | 111 +++++++++++
 tb/tb_load_store_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM state encoding and default memory size for the load/store unit
package lsu_pkg;
  localparam int LSU_MEM_BYTES = 1024;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RDW,
    ST_WR,
    ST_DONE
  } lsu_state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte/half lane extract-and-extend for loads and lane merge for sub-word stores
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b     = rdata[{lane, 3'b000} +: 8];
    lane_h     = rdata[{lane[1], 4'b0000} +: 16];
    load_data  = rdata;
    merge_data = rdata;
    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_data = {24'h0, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_data = {16'h0, lane_h};
      default: load_data = rdata;
    endcase
    // Only the addressed lane is replaced; the rest of the word is kept from memory.
    case (funct3)
      F3_B:    merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
      F3_H:    merge_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: merge_data = wdata;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-request load/store FSM over a word-wide data memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = LSU_MEM_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  lsu_state_t  state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] merge_q;
  logic        err_q;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      F3_B, F3_BU: req_err = 1'b0;
      F3_H, F3_HU: req_err = req_addr[0];
      F3_W:        req_err = |req_addr[1:0];
      default:     req_err = 1'b1;
    endcase
    if (req_we && req_funct3[2]) req_err = 1'b1;
    if (req_addr > LAST_WORD) req_err = 1'b1;
  end

  lsu_lane_align u_lane_align (
    .funct3     (f3_q),
    .lane       (addr_q[1:0]),
    .rdata      (mem_read_data),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      merge_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= 32'h0;
            err_q   <= req_err;
            if (req_err) state <= ST_DONE;
            else if (req_we && req_funct3 == F3_W) state <= ST_WR;
            else state <= ST_RD;
          end
        end
        ST_RD:   state <= ST_RDW;
        ST_RDW: begin
          // Sub-word stores continue to WR with the merged word; loads finish here.
          if (we_q) begin
            merge_q <= merge_data;
            state   <= ST_WR;
          end else begin
            rdata_q <= load_data;
            state   <= ST_DONE;
          end
        end
        ST_WR:   state <= ST_DONE;
        ST_DONE: if (rsp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready      = (state == ST_IDLE) && !rst;
  assign rsp_valid      = (state == ST_DONE) && !rst;
  assign mem_read       = (state == ST_RD) && !rst;
  assign mem_write      = (state == ST_WR) && !rst;
  assign mem_address    = {addr_q[31:2], 2'b00};
  assign mem_write_data = (f3_q == F3_W) ? wdata_q : merge_q;
  assign rsp_rdata      = rdata_q;
  assign rsp_err        = err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vectors, corner sequences and randomized model checks for load_store_unit
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  bit   [31:0] mem_read_data;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  // Word memory seen by the DUT, with access counters.
  bit [31:0] mem [MEM_BYTES/4];
  int rd_count, wr_count, both_count;

  always @(posedge clk) begin
    if (mem_read) mem_read_data <= mem[mem_address[9:2]];
    if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
    if (mem_read) rd_count <= rd_count + 1;
    if (mem_write) wr_count <= wr_count + 1;
    if (mem_read && mem_write) both_count <= both_count + 1;
  end

  // Reference model: flat byte array, sizes and signs from the funct3 rules.
  bit [7:0] ref_mem [MEM_BYTES];

  function automatic void model(input bit we, input bit [2:0] f3, input bit [31:0] a,
                                input bit [31:0] wd, output bit [31:0] rd, output bit err,
                                output int lat);
    int size;
    longint v;
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default:        size = 0;
    endcase
    err = (size == 0) || (we && f3[2]) || (longint'(a) > MEM_BYTES - 4) ||
          (size != 0 && (longint'(a) % size) != 0);
    rd = 32'h0;
    if (err) begin
      lat = 1;
    end else if (we) begin
      for (int i = 0; i < size; i++) ref_mem[a + i] = wd[8*i +: 8];
      lat = (size == 4) ? 2 : 4;
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v += longint'(ref_mem[a + i]) << (8 * i);
      if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
        v -= longint'(1) << (8 * size);
      rd = v[31:0];
      lat = 3;
    end
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_req(input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                         output logic [31:0] rd, output logic err, output int lat,
                         output int nrd, output int nwr);
    int r0, w0, n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    r0 = rd_count; w0 = wr_count;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    rd = rsp_rdata; err = rsp_err;
    nrd = rd_count - r0; nwr = wr_count - w0;
  endtask

  typedef struct {
    bit        we;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] exp_rd;
    bit        exp_err;
    int        exp_lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rd;
    logic err;
    int lat, nrd, nwr, n, mism;
    bit [31:0] m_rd, a, wd;
    bit m_err, we;
    bit [2:0] f3;
    int m_lat;
    logic [31:0] held;

    vecs.push_back('{1'b1, F3_W,   32'h100, 32'h8899AABB, 32'h00000000, 1'b0, 2});
    vecs.push_back('{1'b0, F3_B,   32'h101, 32'h0,        32'hFFFFFFAA, 1'b0, 3});
    vecs.push_back('{1'b1, F3_W,   32'h040, 32'h12345678, 32'h00000000, 1'b0, 2});
    vecs.push_back('{1'b0, F3_BU,  32'h043, 32'h0,        32'h00000012, 1'b0, 3});
    vecs.push_back('{1'b0, F3_H,   32'h042, 32'h0,        32'h00001234, 1'b0, 3});
    vecs.push_back('{1'b1, F3_B,   32'h041, 32'h000000EE, 32'h00000000, 1'b0, 4});
    vecs.push_back('{1'b0, F3_W,   32'h040, 32'h0,        32'h1234EE78, 1'b0, 3});
    vecs.push_back('{1'b0, F3_W,   32'h102, 32'h0,        32'h00000000, 1'b1, 1});
    vecs.push_back('{1'b0, F3_H,   32'h3FF, 32'h0,        32'h00000000, 1'b1, 1});
    vecs.push_back('{1'b1, F3_BU,  32'h040, 32'h0,        32'h00000000, 1'b1, 1});
    vecs.push_back('{1'b0, 3'b011, 32'h040, 32'h0,        32'h00000000, 1'b1, 1});
    vecs.push_back('{1'b1, F3_W,   32'h3FC, 32'hCAFEF00D, 32'h00000000, 1'b0, 2});
    vecs.push_back('{1'b0, F3_W,   32'h3FC, 32'h0,        32'hCAFEF00D, 1'b0, 3});
    vecs.push_back('{1'b0, F3_B,   32'h3FD, 32'h0,        32'h00000000, 1'b1, 1});
    vecs.push_back('{1'b0, F3_HU,  32'h102, 32'h0,        32'h00008899, 1'b0, 3});
    vecs.push_back('{1'b0, F3_H,   32'h102, 32'h0,        32'hFFFF8899, 1'b0, 3});
    vecs.push_back('{1'b1, F3_H,   32'h102, 32'hFFFF1357, 32'h00000000, 1'b0, 4});
    vecs.push_back('{1'b0, F3_W,   32'h100, 32'h0,        32'h1357AABB, 1'b0, 3});
    vecs.push_back('{1'b0, F3_W,   32'h400, 32'h0,        32'h00000000, 1'b1, 1});
    vecs.push_back('{1'b0, F3_B,   32'h100, 32'h0,        32'hFFFFFFBB, 1'b0, 3});
    vecs.push_back('{1'b0, F3_BU,  32'h102, 32'h0,        32'h00000057, 1'b0, 3});

    // Reset state, with a request offered that must be ignored.
    rst = 1'b1; req_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("reset req_ready", {31'h0, req_ready}, 32'h0);
    check("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("reset mem_read", {31'h0, mem_read}, 32'h0);
    check("reset mem_write", {31'h0, mem_write}, 32'h0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check("reset rsp_err", {31'h0, rsp_err}, 32'h0);
    rst = 1'b0; req_valid = 1'b0;
    #1;
    check("post-reset req_ready", {31'h0, req_ready}, 32'h1);

    foreach (vecs[i]) begin
      model(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, m_rd, m_err, m_lat);
      run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, err, lat, nrd, nwr);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
      check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d reads", i), nrd, (vecs[i].exp_lat == 3 || vecs[i].exp_lat == 4) ? 1 : 0);
      check($sformatf("vec%0d writes", i), nwr, (vecs[i].exp_lat == 2 || vecs[i].exp_lat == 4) ? 1 : 0);
    end

    // Response backpressure: LW 0x40 held for 5 cycles.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h40; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("bp first valid", {31'h0, rsp_valid}, 32'h1);
    held = rsp_rdata;
    check("bp rdata", held, 32'h1234EE78);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp hold%0d valid", i), {31'h0, rsp_valid}, 32'h1);
      check($sformatf("bp hold%0d rdata", i), rsp_rdata, 32'h1234EE78);
      check($sformatf("bp hold%0d req_ready", i), {31'h0, req_ready}, 32'h0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp release req_ready", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    check("bp after req_ready", {31'h0, req_ready}, 32'h1);
    check("bp after rsp_valid", {31'h0, rsp_valid}, 32'h0);

    // Reset during the WR cycle of SH 0x40 must abandon the store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_H; req_addr = 32'h40; req_wdata = 32'h0000BEEF;
    n = wr_count;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst-wr in WR", {31'h0, mem_write}, 32'h1);
    rst = 1'b1;
    #1;
    check("rst-wr mem_write gated", {31'h0, mem_write}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst-wr req_ready", {31'h0, req_ready}, 32'h1);
    m_lat = 0;
    repeat (5) begin @(negedge clk); if (rsp_valid) m_lat++; end
    check("rst-wr no response", m_lat, 0);
    check("rst-wr no write", wr_count - n, 0);
    check("rst-wr word", mem[32'h40 >> 2], 32'h1234EE78);

    // Randomized requests against the byte model.
    for (int t = 0; t < 120; t++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom_range(0, MEM_BYTES + 3);
      case ($urandom_range(0, 3))
        0: a[1:0] = 2'b00;
        1: a[0] = 1'b0;
        default: ;
      endcase
      if ($urandom_range(0, 15) == 0) a = a | 32'h8000_0000;
      wd = $urandom;
      model(we, f3, a, wd, m_rd, m_err, m_lat);
      run_req(we, f3, a, wd, rd, err, lat, nrd, nwr);
      check($sformatf("rnd%0d rdata", t), rd, m_rd);
      check($sformatf("rnd%0d err", t), {31'h0, err}, {31'h0, m_err});
      check($sformatf("rnd%0d latency", t), lat, m_lat);
      check($sformatf("rnd%0d accesses", t), nrd * 2 + nwr,
            (m_lat == 4) ? 3 : (m_lat == 3) ? 2 : (m_lat == 2) ? 1 : 0);
    end

    mism = 0;
    for (int w = 0; w < MEM_BYTES / 4; w++)
      if (mem[w] != {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]}) mism++;
    check("final memory words differing", mism, 0);
    check("read and write together", both_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
